// File: rtl/fib_host_ctrl.sv
// Avalon-MM master that programs the Fibonacci slave, polls its status and returns the result.
// Optional poll timeout abort is built only when FIB_HOST_TIMEOUT_EN is defined.
module fib_host_ctrl #(
   parameter int POLL_GAP     = 4,
   parameter int POLL_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] limit,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        err,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write,
   output logic        avm_read,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata
);

   // state   | meaning
   // IDLE    | waiting for start
   // WR_LIM  | write limit to input register
   // WR_CLR  | clear stale status register
   // WR_GO   | write 1 to control register
   // GAP     | idle between status polls
   // POLL_RD | status read strobe
   // POLL_WT | status data valid, decide
   // RES_RD  | result read strobe
   // RES_WT  | result data valid, capture
   // FIN     | done pulse (err on abort)
   typedef enum logic [3:0] {
      S_IDLE, S_WR_LIM, S_WR_CLR, S_WR_GO, S_GAP,
      S_POLL_RD, S_POLL_WT, S_RES_RD, S_RES_WT, S_FIN
   } state_t;

   if (CNT_W < $clog2(POLL_GAP + 1) || CNT_W < $clog2(POLL_TIMEOUT + 1)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for POLL_GAP/POLL_TIMEOUT");
   end

   // First gap after the go write lasts POLL_GAP+1 cycles so the slave sees two
   // cycles before the first poll; later gaps last POLL_GAP cycles, giving a
   // poll spacing of POLL_GAP+2.
   localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(POLL_GAP);
   localparam logic [CNT_W-1:0] GAP_RELOAD = (POLL_GAP == 0) ? '0 : CNT_W'(POLL_GAP - 1);

   state_t            state_q, state_d;
   logic [31:0]       lim_q, lim_d;
   logic [CNT_W-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0]  poll_q, poll_d;
   logic              cs_d, wr_d, rd_d, busy_d, done_d;
   logic [1:0]        addr_d;
   logic [31:0]       wd_d;
`ifdef FIB_HOST_TIMEOUT_EN
   logic              abort_d;
   logic              err_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         lim_q          <= '0;
         gap_q          <= '0;
         poll_q         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         result         <= '0;
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_write      <= 1'b0;
         avm_read       <= 1'b0;
         avm_writedata  <= '0;
      end else begin
         state_q        <= state_d;
         lim_q          <= lim_d;
         gap_q          <= gap_d;
         poll_q         <= poll_d;
         busy           <= busy_d;
         done           <= done_d;
         avm_address    <= addr_d;
         avm_chipselect <= cs_d;
         avm_write      <= wr_d;
         avm_read       <= rd_d;
         avm_writedata  <= wd_d;
         if (state_q == S_RES_WT)
            result <= avm_readdata;
      end
   end

`ifdef FIB_HOST_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= abort_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      lim_d   = lim_q;
      gap_d   = gap_q;
      poll_d  = poll_q;
`ifdef FIB_HOST_TIMEOUT_EN
      abort_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lim_d   = limit;
               state_d = S_WR_LIM;
            end
         end
         S_WR_LIM: state_d = S_WR_CLR;
         S_WR_CLR: state_d = S_WR_GO;
         S_WR_GO: begin
            gap_d   = GAP_INIT;
            poll_d  = '0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == '0)
               state_d = S_POLL_RD;
            else
               gap_d = gap_q - 1'b1;
         end
         S_POLL_RD: begin
            poll_d  = poll_q + 1'b1;
            state_d = S_POLL_WT;
         end
         S_POLL_WT: begin
            if (avm_readdata[0])
               state_d = S_RES_RD;
`ifdef FIB_HOST_TIMEOUT_EN
            else if (poll_q == CNT_W'(POLL_TIMEOUT)) begin
               abort_d = 1'b1;
               state_d = S_FIN;
            end
`endif
            else if (POLL_GAP == 0)
               state_d = S_POLL_RD;
            else begin
               gap_d   = GAP_RELOAD;
               state_d = S_GAP;
            end
         end
         S_RES_RD: state_d = S_RES_WT;
         S_RES_WT: state_d = S_FIN;
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      cs_d   = 1'b0;
      wr_d   = 1'b0;
      rd_d   = 1'b0;
      addr_d = 2'd0;
      wd_d   = '0;
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d = (state_d == S_FIN);
      case (state_d)
         S_WR_LIM: begin
            cs_d = 1'b1; wr_d = 1'b1; addr_d = 2'd0; wd_d = lim_d;
         end
         S_WR_CLR: begin
            cs_d = 1'b1; wr_d = 1'b1; addr_d = 2'd2; wd_d = 32'h0;
         end
         S_WR_GO: begin
            cs_d = 1'b1; wr_d = 1'b1; addr_d = 2'd1; wd_d = 32'h1;
         end
         S_POLL_RD: begin
            cs_d = 1'b1; rd_d = 1'b1; addr_d = 2'd2;
         end
         S_RES_RD: begin
            cs_d = 1'b1; rd_d = 1'b1; addr_d = 2'd3;
         end
         default: ;
      endcase
   end

endmodule
